// File: rtl/sudoku_pkg.sv
// Shared types and constants for the 4x4 Sudoku grid checker.
package sudoku_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int GRID_N    = 4;
  localparam int VAL_W     = 2;
  localparam int NUM_CELLS = GRID_N * GRID_N;
  localparam int BOARD_W   = NUM_CELLS * VAL_W;

  localparam logic [3:0] GRP_ROW0  = 4'd0;
  localparam logic [3:0] GRP_COL0  = 4'd4;
  localparam logic [3:0] GRP_BOX0  = 4'd8;
  localparam logic [3:0] GRP_LAST  = 4'd11;
  localparam logic [3:0] FAIL_NONE = 4'hF;

  // One scanned group: four cell values plus their filled flags.
  typedef struct packed {
    logic [GRID_N-1:0][VAL_W-1:0] val;
    logic [GRID_N-1:0]            fill;
  } grp_cells_t;

  function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
    return {r, c};
  endfunction

  function automatic logic [GRID_N-1:0] one_hot(input logic [VAL_W-1:0] v);
    return 4'b0001 << v;
  endfunction

endpackage

// File: rtl/sudoku_group_sel.sv
// Combinational selector: maps a group index to its four cells in the snapshot.
module sudoku_group_sel
  import sudoku_pkg::*;
(
  input  logic [3:0]           grp_idx,
  input  logic [BOARD_W-1:0]   snap_board,
  input  logic [NUM_CELLS-1:0] snap_filled,
  output grp_cells_t           cells
);

  for (genvar k = 0; k < GRID_N; k++) begin : g_lane
    localparam logic [1:0] K = 2'(k);
    logic [1:0] r, c;
    logic [3:0] idx;

    // Rows sweep columns, columns sweep rows, boxes take a 2x2 quadrant.
    always_comb begin
      r = grp_idx[1:0];
      c = K;
      if (grp_idx >= GRP_BOX0) begin
        r = {grp_idx[1], K[1]};
        c = {grp_idx[0], K[0]};
      end else if (grp_idx >= GRP_COL0) begin
        r = K;
        c = grp_idx[1:0];
      end
    end

    assign idx           = cell_idx(r, c);
    assign cells.val[k]  = snap_board[idx*VAL_W +: VAL_W];
    assign cells.fill[k] = snap_filled[idx];
  end

endmodule

// File: rtl/sudoku_grid_checker.sv
// 4x4 Sudoku validity checker: snapshots the board and scans 12 groups, one per cycle.
module sudoku_grid_checker
  import sudoku_pkg::*;
#(
  parameter int CELL_W = 2,
  parameter int N      = 4
) (
  input  logic                    clka,
  input  logic                    restart,
  input  logic                    dp_check,
  input  logic [N*N*CELL_W-1:0]   board,
  input  logic [N*N-1:0]          filled,
  output logic                    busy,
  output logic                    check_done,
  output logic                    solved,
  output logic [3:0]              fail_grp
);

  if (N != 4 || CELL_W != 2) begin : g_bad_param
    $error("sudoku_grid_checker supports only N=4, CELL_W=2");
  end

  state_t                 state, nxt;
  logic [BOARD_W-1:0]     snap_board;
  logic [NUM_CELLS-1:0]   snap_filled;
  logic [3:0]             grp_idx;
  logic                   err;
  grp_cells_t             cells;
  logic [GRID_N-1:0]      seen;
  logic                   grp_ok;

  sudoku_group_sel u_sel (
    .grp_idx     (grp_idx),
    .snap_board  (snap_board),
    .snap_filled (snap_filled),
    .cells       (cells)
  );

  always_comb begin
    seen = '0;
    for (int k = 0; k < GRID_N; k++) seen |= one_hot(cells.val[k]);
  end

  assign grp_ok = (&cells.fill) && (&seen);
  assign busy   = (state != IDLE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (dp_check) nxt = SCAN;
      SCAN:    if (grp_idx == GRP_LAST) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) state <= IDLE;
    else         state <= nxt;
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      snap_board  <= '0;
      snap_filled <= '0;
      grp_idx     <= GRP_ROW0;
      err         <= 1'b0;
      check_done  <= 1'b0;
      solved      <= 1'b0;
      fail_grp    <= FAIL_NONE;
    end else begin
      check_done <= 1'b0;
      case (state)
        IDLE: if (dp_check) begin
          snap_board  <= board;
          snap_filled <= filled;
          err         <= 1'b0;
          grp_idx     <= GRP_ROW0;
          solved      <= 1'b0;
        end
        SCAN: begin
          // Only the first failing group is recorded.
          if (!grp_ok && !err) begin
            err      <= 1'b1;
            fail_grp <= grp_idx;
          end
          if (grp_idx != GRP_LAST) grp_idx <= grp_idx + 4'd1;
        end
        DONE: begin
          check_done <= 1'b1;
          solved     <= ~err;
          if (!err) fail_grp <= FAIL_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule
